// File: rtl/read_seq_pkg.sv
// Shared types and defaults for the result-RAM read sequencer.
package read_seq_pkg;
  typedef enum logic [1:0] {RS_IDLE, RS_READ, RS_FINISH} rs_state_e;
  localparam int RS_ADDR_W = 9;
  localparam int RS_DATA_W = 32;
endpackage

// File: rtl/rs_out_buf.sv
// Two-entry output FIFO absorbing RAM read latency; head entry drives the stream.
module rs_out_buf
  import read_seq_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [1:0][DATA_W-1:0] mem;
  logic                   wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];

  // The issue logic upstream must never push into a full buffer without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == 2'd2));
endmodule

// File: rtl/read_sequencer.sv
// Replays a written block of the result RAM as a valid/ready stream.
// Optional READ_SEQ_REVERSE_EN: stream addresses in descending order.
module read_sequencer
  import read_seq_pkg::*;
#(
  parameter int ADDR_W = RS_ADDR_W,
  parameter int DATA_W = RS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] ONE = ADDR_W'(1);

  rs_state_e       state, state_nxt;
  logic [ADDR_W:0] len, issued, popped, popped_nxt;
  logic [1:0]      occ;
  logic            inflight, pop;

  assign pop        = out_valid & out_ready;
  assign popped_nxt = popped + {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RS_IDLE:   if (start) state_nxt = (wr_cnt == '0) ? RS_FINISH : RS_READ;
      RS_READ:   if (popped_nxt == len) state_nxt = RS_FINISH;
      RS_FINISH: state_nxt = RS_IDLE;
      default:   state_nxt = RS_IDLE;
    endcase
  end

  // Issue only when the buffer can hold every outstanding word after this cycle's pop.
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      RS_READ: begin
        busy  = 1'b1;
        rd_en = (issued < len) && ({1'b0, occ} + 3'(inflight) < 3'd2 + 3'(pop));
      end
      RS_FINISH: begin
        done = 1'b1;
        busy = (len == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len      <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (state == RS_IDLE && start) begin
        len    <= {1'b0, wr_cnt};
        issued <= '0;
        popped <= '0;
      end else begin
        if (rd_en) issued <= issued + ONE;
        if (state == RS_READ && pop) popped <= popped_nxt;
      end
    end
  end

`ifdef READ_SEQ_REVERSE_EN
  assign rd_addr = rd_en ? ADDR_W'(len - ONE - issued) : '0;
`else
  assign rd_addr = rd_en ? ADDR_W'(issued) : '0;
`endif

  rs_out_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .occ       (occ),
    .out_valid (out_valid),
    .out_data  (out_data)
  );
endmodule

// File: tb/tb_read_sequencer.sv
// Bench for read_sequencer: table of passes, random passes, mid-pass reset.
module tb_read_sequencer;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, start, rd_en, out_valid, out_ready, busy, done;
  logic [ADDR_W-1:0] wr_cnt, rd_addr;
  logic [DATA_W-1:0] rd_data, out_data;
  logic [DATA_W-1:0] ram [512];

  int total = 0;
  int bad   = 0;

  read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_cnt(wr_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  typedef struct {
    int n;       // wr_cnt
    int mode;    // 0: ready=1, 1: ready 1,0,0,1 repeating, 2: random
    int exp_fv;  // first out_valid cycle after start edge; -1 never; -2 unchecked
    int exp_dn;  // done cycle; -2 unchecked
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic chk_reset_vals();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  // Entered and left just after a rising edge. abort_hs>=0 returns at the
  // falling edge after that many handshakes, without waiting for done.
  task automatic do_pass(input vec_t v, input int abort_hs);
    int exp_addr[$];
    int issue_idx = 0, hs = 0, last_hs = -1, first_v = -1, cyc;
    bit done_seen = 0, prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    int budget = 4 * v.n + 40;
    for (int i = 0; i < v.n; i++) begin
`ifdef READ_SEQ_REVERSE_EN
      exp_addr.push_back(v.n - 1 - i);
`else
      exp_addr.push_back(i);
`endif
    end
    start = 1'b1; wr_cnt = ADDR_W'(v.n); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc < budget && !done_seen; cyc++) begin
      bit pop_now;
      out_ready = ready_of(v.mode, cyc - 1);
      @(negedge clk);
      pop_now = out_valid && out_ready;
      if (rd_en) begin
        if (issue_idx < v.n) chk("rd_addr", rd_addr, exp_addr[issue_idx]);
        else chk("issue_overrun", issue_idx, v.n);
        chk("buf_room", ((issue_idx - hs - int'(pop_now)) < 2), 1);
        issue_idx++;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (pop_now) begin
        if (hs < v.n) chk("out_data", out_data, ram[exp_addr[hs]]);
        else chk("extra_word", hs, v.n);
        hs++;
        last_hs = cyc;
      end
      if (done) begin
        done_seen = 1;
        chk("done_cycle", cyc, (v.n == 0) ? 1 : last_hs + 1);
        chk("word_count", hs, v.n);
        chk("issue_count", issue_idx, v.n);
        chk("busy_at_done", busy, (v.n == 0));
        if (v.exp_dn != -2) chk("done_abs", cyc, v.exp_dn);
      end else begin
        chk("busy", busy, 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (abort_hs >= 0 && hs == abort_hs) return;
      @(posedge clk); #1;
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    if (v.exp_fv != -2) chk("first_valid", first_v, v.exp_fv);
    @(negedge clk);
    chk("idle_after", {busy, done, out_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    for (int i = 0; i < 512; i++) ram[i] = $urandom;
    tbl[0] = '{4,   0,  3,   7};
    tbl[1] = '{0,   0, -1,   1};
    tbl[2] = '{1,   0,  3,   4};
    tbl[3] = '{8,   1, -2,  -2};
    tbl[4] = '{2,   0,  3,   5};
    tbl[5] = '{511, 0,  3, 514};
    tbl[6] = '{5,   2, -2,  -2};
    tbl[7] = '{3,   1, -2,  -2};

    rst_n = 1'b0; start = 1'b0; wr_cnt = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_pass(tbl[i], -1);

    for (int i = 0; i < 20; i++) begin
      v = '{int'($urandom_range(0, 40)), 2, -2, -2};
      do_pass(v, -1);
    end

    // Reset mid-pass after three words; no done, then a clean short pass.
    v = '{10, 0, -2, -2};
    do_pass(v, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_quiet", {done, out_valid, rd_en}, 0);
    end
    @(posedge clk); #1;
    v = '{2, 0, 3, 5};
    do_pass(v, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
